trig_route: RTL and testbench
=============================

Name: trig_route

Overview:
- Parametrised trigger router/conditioner, successor to the fixed 2-source trigger-out mux (soft-trigger passthrough vs trace trigger) on the target top-level.
- Combines pNUM_SRC trigger sources into pNUM_OUT independent outputs (trig_out, trig_out_dbg, scope/glitch lines) with per-output source mask, OR/AND combine, arming, one-shot, pulse stretch and shared holdoff.
- Provides per-output fire/missed counters for register readback, plus a quiet flag used to freeze the LED/activity counters while any trigger is active.
- Sits in fe_clk domain; sources are pre-synchronised by the caller.

Parameters:
- pNUM_SRC, 4, number of trigger source inputs (2..16)
- pNUM_OUT, 2, number of routed trigger outputs (1..8)
- pSTRETCH_WIDTH, 8, width of per-output pulse-stretch value
- pHOLDOFF_WIDTH, 16, width of shared holdoff value
- pCOUNT_WIDTH, 16, width of each fire/missed counter

Ports:
- fe_clk  in  1  sole clock
- resetn  in  1  reset; synchronous, active-low
- I_src  in  pNUM_SRC  trigger sources, level
- I_src_mask  in  pNUM_OUT*pNUM_SRC  per-output source enable; output k uses bits [k*pNUM_SRC +: pNUM_SRC]
- I_mode_and  in  pNUM_OUT  per-output combine: 0 = OR of masked sources, 1 = AND
- I_stretch  in  pNUM_OUT*pSTRETCH_WIDTH  per-output extra high cycles
- I_holdoff  in  pHOLDOFF_WIDTH  cycles after a pulse during which new edges are ignored
- I_oneshot  in  pNUM_OUT  1 = return to IDLE after one trigger
- I_arm  in  pNUM_OUT  arm pulse per output
- I_disarm  in  pNUM_OUT  disarm pulse per output
- I_clear_counts  in  1  clear all counters
- O_trig  out  pNUM_OUT  routed triggers, registered
- O_armed  out  pNUM_OUT  1 when output is not IDLE
- O_fire_count  out  pNUM_OUT*pCOUNT_WIDTH  pulses issued per output
- O_missed_count  out  pNUM_OUT*pCOUNT_WIDTH  edges dropped in FIRE/HOLDOFF per output
- O_quiet  out  1  registered; 1 when no output is in FIRE

Behaviour:
- Reset (resetn=0 at fe_clk edge): all FSMs IDLE, O_trig=0, O_armed=0, counters=0, O_quiet=1, cond history=0.
- Combine: OR: cond=|(src&mask). AND: cond=&(src|~mask) & |mask. Mask all zero gives cond=0 in both modes.
- Edge: cond_r registered each cycle; edge = cond & ~cond_r. History updates in all states, so a level high at arm time does not fire.
- Per-output FSM: IDLE, ARMED, FIRE, HOLDOFF.
- IDLE -> ARMED on I_arm. An edge in the same cycle as arm is not taken.
- ARMED -> FIRE on edge; same edge sets O_trig=1 (1-cycle latency from source) and loads cnt=I_stretch (sampled here); fire_count++.
- FIRE: O_trig stays high for stretch+1 cycles total (stretch=0 gives a 1-cycle pulse). When cnt=0, O_trig<=0:
  - holdoff!=0: -> HOLDOFF, load I_holdoff (sampled here).
  - holdoff=0: -> ARMED, or IDLE if oneshot.
- HOLDOFF: decrement; on 1 -> ARMED, or IDLE if I_oneshot (sampled at exit). Holdoff H gives exactly H cycles of O_trig=0 before re-arm.
- Edges in FIRE/HOLDOFF: missed_count++, no other effect.
- I_disarm: any state -> IDLE next edge, O_trig<=0. Disarm beats arm and edge in the same cycle.
- I_arm while not IDLE: ignored.
- Counters saturate at all-ones.
- I_clear_counts zeroes all counters; clear beats a simultaneous increment.
- O_armed = (state!=IDLE), registered with state.
- O_quiet <= ~|(next FIRE states), aligned with O_trig: O_quiet=0 exactly when any O_trig=1.
- Mid-operation config changes: mask/mode take effect on the next cond sample; stretch/holdoff/oneshot affect only later sampling points.

Optional Feature:
- TRIG_ROUTE_PASSTHRU_EN: adds input I_passthru [pNUM_OUT].
  - When I_passthru[k]=1: O_trig[k] = registered cond of output k (1-cycle latency, level-following, no arm/stretch/holdoff needed); FSM, counters and O_armed still run unchanged.
  - O_quiet also goes low whenever a passthrough output is high.
- Without macro: port absent; O_trig driven by FSM only.

Test Plan:
- Reset: hold resetn=0 with I_src=all ones -> O_trig=0, O_armed=0, counts=0, O_quiet=1; release, no trigger without arm.
- OR routing: out0 mask=4'b0010, stretch=3, holdoff=0, arm; pulse src[1] for 1 cycle -> O_trig[0] high 4 cycles starting 1 cycle after edge; fire_count[0]=1, O_quiet low for same 4 cycles; out1 unaffected.
- AND plus level-at-arm: out1 mode_and=1, mask=4'b0101; src[0] held high, arm, then raise src[2] -> single fire. Arm again with both already high -> no fire until a fall and re-rise.
- Holdoff/missed: stretch=0, holdoff=10; edges at t=0, 5, 12 -> fires at t=0 and t=12; missed_count=1 for the t=5 edge.
- Oneshot and disarm: oneshot=1 -> after one fire O_armed=0 and further edges give no pulse. Arm, then assert disarm mid-stretch with arm in the same cycle -> O_trig drops next cycle, state IDLE.
- Saturation/clear: pCOUNT_WIDTH=4; 20 fires -> fire_count=15. clear_counts concurrent with a fire -> 0.

Source files
------------

// File: rtl/trig_route.sv
// trig_route: masked OR/AND trigger combine, per-output arm/fire/holdoff FSM, counters.
// Optional TRIG_ROUTE_PASSTHRU_EN adds I_passthru for level-following outputs.
module trig_route #(
    parameter int pNUM_SRC       = 4,
    parameter int pNUM_OUT       = 2,
    parameter int pSTRETCH_WIDTH = 8,
    parameter int pHOLDOFF_WIDTH = 16,
    parameter int pCOUNT_WIDTH   = 16
) (
    input  logic                               fe_clk,
    input  logic                               resetn,
    input  logic [pNUM_SRC-1:0]                I_src,
    input  logic [pNUM_OUT*pNUM_SRC-1:0]       I_src_mask,
    input  logic [pNUM_OUT-1:0]                I_mode_and,
    input  logic [pNUM_OUT*pSTRETCH_WIDTH-1:0] I_stretch,
    input  logic [pHOLDOFF_WIDTH-1:0]          I_holdoff,
    input  logic [pNUM_OUT-1:0]                I_oneshot,
    input  logic [pNUM_OUT-1:0]                I_arm,
    input  logic [pNUM_OUT-1:0]                I_disarm,
    input  logic                               I_clear_counts,
`ifdef TRIG_ROUTE_PASSTHRU_EN
    input  logic [pNUM_OUT-1:0]                I_passthru,
`endif
    output logic [pNUM_OUT-1:0]                O_trig,
    output logic [pNUM_OUT-1:0]                O_armed,
    output logic [pNUM_OUT*pCOUNT_WIDTH-1:0]   O_fire_count,
    output logic [pNUM_OUT*pCOUNT_WIDTH-1:0]   O_missed_count,
    output logic                               O_quiet
);

    localparam int CW = (pSTRETCH_WIDTH > pHOLDOFF_WIDTH) ? pSTRETCH_WIDTH : pHOLDOFF_WIDTH;
    localparam int SW = pSTRETCH_WIDTH;
    localparam int NW = pCOUNT_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_FIRE, ST_HOLDOFF} state_t;

    state_t [pNUM_OUT-1:0]          state_q, state_d;
    logic   [pNUM_OUT-1:0][CW-1:0]  cnt_q, cnt_d;
    logic   [pNUM_OUT-1:0][NW-1:0]  fire_cnt_q, fire_cnt_d;
    logic   [pNUM_OUT-1:0][NW-1:0]  miss_cnt_q, miss_cnt_d;
    logic   [pNUM_OUT-1:0]          cond, cond_r_q, cond_r_d, edge_det;
    logic   [pNUM_OUT-1:0]          fire_inc, miss_inc, fsm_trig, fire_next, pass_hi;
    logic   [pNUM_OUT-1:0]          trig_q, trig_d, armed_q, armed_d;
    logic                           quiet_q, quiet_d;

    always_comb begin
        logic [pNUM_SRC-1:0] m;
        m = '0;
        for (int k = 0; k < pNUM_OUT; k++) begin
            m = I_src_mask[k*pNUM_SRC +: pNUM_SRC];
            if (I_mode_and[k])
                cond[k] = (&(I_src | ~m)) & (|m);
            else
                cond[k] = |(I_src & m);
        end
        cond_r_d = cond;
        edge_det = cond & ~cond_r_q;
    end

    always_comb begin
        for (int k = 0; k < pNUM_OUT; k++) begin
            state_d[k]  = state_q[k];
            cnt_d[k]    = cnt_q[k];
            fsm_trig[k] = 1'b0;
            fire_inc[k] = 1'b0;
            miss_inc[k] = 1'b0;
            // Disarm wins over arm and any edge in the same cycle.
            if (I_disarm[k]) begin
                state_d[k] = ST_IDLE;
            end else begin
                unique case (state_q[k])
                    ST_IDLE: begin
                        if (I_arm[k])
                            state_d[k] = ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (edge_det[k]) begin
                            state_d[k]  = ST_FIRE;
                            cnt_d[k]    = CW'(I_stretch[k*SW +: SW]);
                            fsm_trig[k] = 1'b1;
                            fire_inc[k] = 1'b1;
                        end
                    end
                    ST_FIRE: begin
                        miss_inc[k] = edge_det[k];
                        if (cnt_q[k] == '0) begin
                            if (I_holdoff != '0) begin
                                state_d[k] = ST_HOLDOFF;
                                cnt_d[k]   = CW'(I_holdoff);
                            end else begin
                                state_d[k] = I_oneshot[k] ? ST_IDLE : ST_ARMED;
                            end
                        end else begin
                            cnt_d[k]    = cnt_q[k] - CW'(1);
                            fsm_trig[k] = 1'b1;
                        end
                    end
                    ST_HOLDOFF: begin
                        miss_inc[k] = edge_det[k];
                        if (cnt_q[k] == CW'(1))
                            state_d[k] = I_oneshot[k] ? ST_IDLE : ST_ARMED;
                        else
                            cnt_d[k] = cnt_q[k] - CW'(1);
                    end
                    default: state_d[k] = ST_IDLE;
                endcase
            end
            fire_next[k] = (state_d[k] == ST_FIRE);
            armed_d[k]   = (state_d[k] != ST_IDLE);
        end
    end

    always_comb begin
        for (int k = 0; k < pNUM_OUT; k++) begin
            fire_cnt_d[k] = fire_cnt_q[k];
            miss_cnt_d[k] = miss_cnt_q[k];
            if (I_clear_counts) begin
                fire_cnt_d[k] = '0;
                miss_cnt_d[k] = '0;
            end else begin
                if (fire_inc[k] && (fire_cnt_q[k] != '1))
                    fire_cnt_d[k] = fire_cnt_q[k] + NW'(1);
                if (miss_inc[k] && (miss_cnt_q[k] != '1))
                    miss_cnt_d[k] = miss_cnt_q[k] + NW'(1);
            end
        end
    end

    always_comb begin
`ifdef TRIG_ROUTE_PASSTHRU_EN
        pass_hi = I_passthru & cond;
        trig_d  = pass_hi | (~I_passthru & fsm_trig);
`else
        pass_hi = '0;
        trig_d  = fsm_trig;
`endif
        quiet_d = ~|(fire_next | pass_hi);
    end

    always_ff @(posedge fe_clk) begin
        if (!resetn) begin
            for (int k = 0; k < pNUM_OUT; k++) begin
                state_q[k]    <= ST_IDLE;
                cnt_q[k]      <= '0;
                fire_cnt_q[k] <= '0;
                miss_cnt_q[k] <= '0;
            end
            cond_r_q <= '0;
            trig_q   <= '0;
            armed_q  <= '0;
            quiet_q  <= 1'b1;
        end else begin
            for (int k = 0; k < pNUM_OUT; k++) begin
                state_q[k]    <= state_d[k];
                cnt_q[k]      <= cnt_d[k];
                fire_cnt_q[k] <= fire_cnt_d[k];
                miss_cnt_q[k] <= miss_cnt_d[k];
            end
            cond_r_q <= cond_r_d;
            trig_q   <= trig_d;
            armed_q  <= armed_d;
            quiet_q  <= quiet_d;
        end
    end

    always_comb begin
        for (int k = 0; k < pNUM_OUT; k++) begin
            O_fire_count[k*NW +: NW]   = fire_cnt_q[k];
            O_missed_count[k*NW +: NW] = miss_cnt_q[k];
        end
    end

    assign O_trig  = trig_q;
    assign O_armed = armed_q;
    assign O_quiet = quiet_q;

endmodule

// File: tb/tb_trig_route.sv
// Directed bench for trig_route: reset, OR/AND routing, holdoff, oneshot/disarm,
// counter saturation and clear (4-bit counters).
module tb_trig_route;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  src;
    logic [7:0]  mask;
    logic [1:0]  mode_and;
    logic [15:0] stretch;
    logic [15:0] holdoff;
    logic [1:0]  oneshot;
    logic [1:0]  arm;
    logic [1:0]  disarm;
    logic        clr;
    logic [1:0]  trig;
    logic [1:0]  armed;
    logic [7:0]  fire_cnt;
    logic [7:0]  miss_cnt;
    logic        quiet;

    int checks   = 0;
    int failures = 0;

    trig_route #(
        .pNUM_SRC(4), .pNUM_OUT(2), .pSTRETCH_WIDTH(8),
        .pHOLDOFF_WIDTH(16), .pCOUNT_WIDTH(4)
    ) dut (
        .fe_clk         (clk),
        .resetn         (resetn),
        .I_src          (src),
        .I_src_mask     (mask),
        .I_mode_and     (mode_and),
        .I_stretch      (stretch),
        .I_holdoff      (holdoff),
        .I_oneshot      (oneshot),
        .I_arm          (arm),
        .I_disarm       (disarm),
        .I_clear_counts (clr),
`ifdef TRIG_ROUTE_PASSTHRU_EN
        .I_passthru     (2'b00),
`endif
        .O_trig         (trig),
        .O_armed        (armed),
        .O_fire_count   (fire_cnt),
        .O_missed_count (miss_cnt),
        .O_quiet        (quiet)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0] src;
        logic [1:0] trig;
        logic [1:0] armed;
        logic       quiet;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{src: 4'b0010, trig: 2'b01, armed: 2'b01, quiet: 1'b0};
        tbl[1] = '{src: 4'b0000, trig: 2'b01, armed: 2'b01, quiet: 1'b0};
        tbl[2] = '{src: 4'b0000, trig: 2'b01, armed: 2'b01, quiet: 1'b0};
        tbl[3] = '{src: 4'b0000, trig: 2'b01, armed: 2'b01, quiet: 1'b0};
        tbl[4] = '{src: 4'b0000, trig: 2'b00, armed: 2'b01, quiet: 1'b1};
        tbl[5] = '{src: 4'b0000, trig: 2'b00, armed: 2'b01, quiet: 1'b1};

        resetn = 1'b0; src = 4'hF; mask = 8'hFF; mode_and = 2'b00;
        stretch = 16'h0; holdoff = 16'h0; oneshot = 2'b00;
        arm = 2'b00; disarm = 2'b00; clr = 1'b0;
        repeat (3) tick();
        chk("rst_trig", trig, 2'b00);
        chk("rst_armed", armed, 2'b00);
        chk("rst_fire", fire_cnt, 8'h00);
        chk("rst_miss", miss_cnt, 8'h00);
        chk("rst_quiet", quiet, 1'b1);

        resetn = 1'b1;
        mask = 8'b1000_0010;
        stretch = 16'h0003;
        src = 4'hF; tick();
        src = 4'h0; tick();
        src = 4'hF; tick();
        chk("noarm_trig", trig, 2'b00);
        chk("noarm_fire", fire_cnt, 8'h00);
        src = 4'h0; tick();

        // OR routing with stretch 3
        arm = 2'b01; tick(); arm = 2'b00;
        chk("or_armed", armed, 2'b01);
        for (int i = 0; i < 6; i++) begin
            src = tbl[i].src;
            tick();
            chk($sformatf("or_trig_%0d", i), trig, tbl[i].trig);
            chk($sformatf("or_armed_%0d", i), armed, tbl[i].armed);
            chk($sformatf("or_quiet_%0d", i), quiet, tbl[i].quiet);
        end
        chk("or_fire", fire_cnt, 8'h01);
        chk("or_miss", miss_cnt, 8'h00);

        // AND combine and level-at-arm
        mask = 8'b0101_0010; mode_and = 2'b10; stretch = 16'h0003;
        disarm = 2'b01; tick(); disarm = 2'b00;
        src = 4'b0001; tick();
        arm = 2'b10; tick(); arm = 2'b00;
        chk("and_armed", armed, 2'b10);
        src = 4'b0101; tick();
        chk("and_trig", trig, 2'b10);
        chk("and_quiet", quiet, 1'b0);
        tick();
        chk("and_trig_end", trig, 2'b00);
        tick();
        chk("and_rearmed", armed, 2'b10);
        chk("and_fire", fire_cnt, 8'h11);
        disarm = 2'b10; tick(); disarm = 2'b00;
        chk("and_disarmed", armed, 2'b00);
        arm = 2'b10; tick(); arm = 2'b00;
        repeat (3) tick();
        chk("and_level_nofire", trig, 2'b00);
        chk("and_level_fire", fire_cnt, 8'h11);
        src = 4'b0001; tick();
        src = 4'b0101; tick();
        chk("and_refire", trig, 2'b10);
        chk("and_fire2", fire_cnt, 8'h21);
        tick();

        // Holdoff 10 with edges at t=0,5,12
        disarm = 2'b11; tick(); disarm = 2'b00;
        mode_and = 2'b00; src = 4'h0;
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_fire", fire_cnt, 8'h00);
        stretch = 16'h0000; holdoff = 16'd10;
        arm = 2'b01; tick(); arm = 2'b00;
        for (int t = 0; t < 15; t++) begin
            src = (t == 0 || t == 5 || t == 12) ? 4'b0010 : 4'b0000;
            tick();
            chk($sformatf("ho_trig_t%0d", t), trig,
                (t == 0 || t == 12) ? 2'b01 : 2'b00);
        end
        src = 4'h0;
        chk("ho_fire", fire_cnt, 8'h02);
        chk("ho_miss", miss_cnt, 8'h01);

        // Oneshot
        disarm = 2'b01; tick(); disarm = 2'b00;
        holdoff = 16'h0; oneshot = 2'b01;
        arm = 2'b01; tick(); arm = 2'b00;
        src = 4'b0010; tick();
        chk("os_trig", trig, 2'b01);
        src = 4'b0000; tick();
        chk("os_trig_end", trig, 2'b00);
        chk("os_idle", armed, 2'b00);
        src = 4'b0010; tick();
        chk("os_nofire", trig, 2'b00);
        src = 4'b0000; tick();

        // Disarm mid-stretch with simultaneous arm
        stretch = 16'h0005; oneshot = 2'b00;
        arm = 2'b01; tick(); arm = 2'b00;
        src = 4'b0010; tick();
        chk("dis_trig", trig, 2'b01);
        src = 4'b0000; tick();
        chk("dis_trig_hold", trig, 2'b01);
        disarm = 2'b01; arm = 2'b01; tick(); disarm = 2'b00; arm = 2'b00;
        chk("dis_trig_drop", trig, 2'b00);
        chk("dis_armed", armed, 2'b00);
        chk("dis_quiet", quiet, 1'b1);
        tick();
        chk("dis_stay_idle", trig, 2'b00);

        // Saturation and clear
        stretch = 16'h0000;
        clr = 1'b1; tick(); clr = 1'b0;
        arm = 2'b01; tick(); arm = 2'b00;
        repeat (20) begin
            src = 4'b0010; tick();
            src = 4'b0000; tick();
        end
        chk("sat_fire", fire_cnt, 8'h0F);
        chk("sat_miss", miss_cnt, 8'h00);
        src = 4'b0010; clr = 1'b1; tick();
        src = 4'b0000; clr = 1'b0;
        chk("clr_fire_trig", trig, 2'b01);
        chk("clr_beats_inc", fire_cnt, 8'h00);
        tick();
        chk("clr_after", fire_cnt, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
